mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage CPU pipeline, between EX_MEM and MEM_WB. It passes ALU results straight through and runs loads and stores over a request/acknowledge data-memory bus. It formats load and store data by size and sign, and holds the pipeline with `stall_req` while a bus access is outstanding. Its `mem_*` outputs feed MEM_WB directly.

## Interface
- `TIMEOUT`, 255: BUSY cycles without `dmem_ack` before the access is abandoned (8-bit counter).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high.
- `ex_write_reg` in 5: destination register from EX_MEM.
- `ex_we` in 1: register write enable from EX_MEM.
- `ex_write_data` in 32: ALU result; for stores, not used.
- `ex_mem_op` in 4: memory operation (package enum).
- `ex_mem_addr` in 32: effective byte address.
- `ex_store_data` in 32: rt value for stores.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word address, `{ex_mem_addr[31:2],2'b00}`.
- `dmem_be` out 4: byte enables, little-endian lane i = bits 8i+7:8i.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_rdata` in 32: read word, valid when `dmem_ack`=1.
- `dmem_ack` in 1: access complete, one cycle.
- `mem_write_reg` out 5: to MEM_WB.
- `mem_we` out 1: to MEM_WB.
- `mem_write_data` out 32: to MEM_WB.
- `stall_req` out 1: freeze PC/IF_ID/ID_EX/EX_MEM; MEM_WB must still clock.
- `exc_misalign` out 1: one-cycle flag, misaligned access.
- `exc_bus` out 1: one-cycle flag, bus timeout.

## Operation
- Memory ops:
  - NONE: pass-through, with `mem_*` = `ex_*` combinationally and no stall.
  - Loads: LB, LBU, LH, LHU, LW.
  - Stores: SB, SH, SW.
- Alignment rules:
  - Halfword ops need `addr[0]`=0.
  - Word ops need `addr[1:0]`=0.
  - A misaligned access issues no bus request and no stall; it gives `mem_we`=0 and `exc_misalign`=1 for that cycle.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - On a valid memory op: drive `dmem_req`=1, `stall_req`=1.
  - If `dmem_ack`=1 at the edge, go to DONE; otherwise go to BUSY and clear the counter.
- BUSY:
  - Hold `dmem_req`=1 with stable bus fields; `stall_req`=1; counter increments.
  - If `dmem_ack`=1, go to DONE.
  - If the counter reaches `TIMEOUT`-1 with no ack, go to DONE with the error flag set.
- DONE:
  - `dmem_req`=0, `stall_req`=0.
  - Outputs the captured result; the pipeline advances at this edge.
  - Always returns to IDLE, so the same instruction is never reissued.
- Load data is captured from `dmem_rdata` on the ack edge into `rdata_q`.
- Load formatting in DONE:
  - LB/LBU select byte `addr[1:0]`; LH/LHU select half `addr[1]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word.
  - Result gives `mem_we`=`ex_we`.
- Stores:
  - SB: `be` = 1<<`addr[1:0]`, wdata = byte×4.
  - SH: `be` = `addr[1]`?1100:0011, wdata = half×2.
  - SW: `be`=1111.
  - `mem_we`=0 in DONE.
- Timeout in DONE gives `mem_we`=0, `exc_bus`=1, and any late ack is ignored.
- Reset values (`rst`=1 gates all outputs):
  - `dmem_req`=0, `dmem_we`=0, `dmem_be`=0.
  - `stall_req`=0, `mem_we`=0.
  - `mem_write_reg`=NOPRegAddr, `mem_write_data`=ZeroWord.
  - `exc_*`=0.
  - state=IDLE, counter=0, `rdata_q`=0.
- Reset mid-access drops the request immediately. The bus slave must tolerate an abandoned request.

## Timing
- Non-memory ops have zero added latency.
- Memory ops take 1 + N stall cycles, where N = ack wait cycles. A zero-wait ack gives 1 stall cycle, then DONE.
- EX_MEM inputs must be stable from IDLE through DONE; the stage relies on `stall_req` to guarantee this.
- `stall_req` is combinational from state and the inputs; it must not depend on `dmem_ack`.
- Maximum access is `TIMEOUT`+1 stall cycles.

## Structure
- Shared package/defines:
  - mem_op enum (NONE=0, LB, LBU, LH, LHU, LW, SB, SH, SW).
  - FSM state encoding.
  - NOPRegAddr and ZeroWord.
- One sub-module, `load_align`: combinational byte/half selection and sign extension from `rdata_q`, `addr[1:0]` and the op.
- The store lane logic stays inline.

## Test plan
- ALU op, `ex_write_data`=0x1234, reg 5, we=1: same cycle `mem_*` = 5/1/0x1234, `stall_req`=0, `dmem_req`=0.
- LB at addr 0x103, ack after 2 cycles with rdata 0x80FF_0011:
  - Stall for 3 cycles.
  - DONE gives data 0xFFFF_FF80, `mem_we`=1.
- SH at 0x202, store data 0x0000_ABCD, zero-wait ack:
  - Bus shows addr 0x200, be=1100, wdata 0xABCD_ABCD.
  - 1 stall cycle; DONE gives `mem_we`=0.
- LW at 0x101: no `dmem_req`, `exc_misalign`=1 for one cycle, `mem_we`=0, no stall.
- LW with no ack and `TIMEOUT`=4:
  - `stall_req` high for 5 cycles.
  - DONE gives `exc_bus`=1, `mem_we`=0; an ack arriving the next cycle is ignored.
- `rst` asserted in BUSY: the next cycle has `dmem_req`=0, state IDLE, and all outputs at their reset values.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [4:0]  NOPRegAddr = 5'd0;
  localparam logic [31:0] ZeroWord   = 32'd0;

  function automatic logic is_load(input mem_op_e op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic misaligned(input mem_op_e op, input logic [1:0] addr);
    logic r;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: r = addr[0];
      MEM_LW, MEM_SW:          r = |addr;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword of a captured read word and extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  mem_op_e     op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (op_i)
      MEM_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data_o = {24'd0, byte_sel};
      MEM_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: ALU pass-through plus load/store over a req/ack data bus,
// stalling the front of the pipeline while an access is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_write_reg,
  input  logic        ex_we,
  input  logic [31:0] ex_write_data,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [4:0]  mem_write_reg,
  output logic        mem_we,
  output logic [31:0] mem_write_data,
  output logic        stall_req,
  output logic        exc_misalign,
  output logic        exc_bus
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        timeout_q;

  mem_op_e     op;
  logic        op_load, op_store, op_mis, op_valid;
  logic [3:0]  lane_be;
  logic [31:0] load_data;

  assign op       = mem_op_e'(ex_mem_op);
  assign op_load  = is_load(op);
  assign op_store = is_store(op);
  assign op_mis   = misaligned(op, ex_mem_addr[1:0]);
  assign op_valid = (op_load || op_store) && !op_mis;

  load_align u_load_align (
    .rdata_i (rdata_q),
    .addr_i  (ex_mem_addr[1:0]),
    .op_i    (op),
    .data_o  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            if (dmem_ack) begin
              rdata_q <= dmem_rdata;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + 8'd1;
          // An ack on the final counted cycle still wins over the timeout.
          if (dmem_ack) begin
            rdata_q <= dmem_rdata;
            state_q <= ST_DONE;
          end else if (cnt_q == CntLast) begin
            timeout_q <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (op)
      MEM_SB, MEM_LB, MEM_LBU: lane_be = 4'b0001 << ex_mem_addr[1:0];
      MEM_SH, MEM_LH, MEM_LHU: lane_be = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
      default:                 lane_be = 4'b1111;
    endcase
    case (op)
      MEM_SB:  dmem_wdata = {4{ex_store_data[7:0]}};
      MEM_SH:  dmem_wdata = {2{ex_store_data[15:0]}};
      default: dmem_wdata = ex_store_data;
    endcase
  end

  assign dmem_addr = {ex_mem_addr[31:2], 2'b00};

  always_comb begin
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    dmem_be        = '0;
    stall_req      = 1'b0;
    mem_write_reg  = ex_write_reg;
    mem_we         = ex_we;
    mem_write_data = ex_write_data;
    exc_misalign   = 1'b0;
    exc_bus        = 1'b0;
    if (rst) begin
      mem_write_reg  = NOPRegAddr;
      mem_we         = 1'b0;
      mem_write_data = ZeroWord;
    end else begin
      case (state_q)
        ST_IDLE, ST_BUSY: begin
          if (state_q == ST_BUSY || op_valid) begin
            // MEM_WB keeps clocking during the stall, so feed it a bubble.
            dmem_req       = 1'b1;
            dmem_we        = op_store;
            dmem_be        = lane_be;
            stall_req      = 1'b1;
            mem_write_reg  = NOPRegAddr;
            mem_we         = 1'b0;
            mem_write_data = ZeroWord;
          end else if (op_mis) begin
            mem_we       = 1'b0;
            exc_misalign = 1'b1;
          end
        end
        default: begin
          if (timeout_q) begin
            mem_we  = 1'b0;
            exc_bus = 1'b1;
          end else if (op_load) begin
            mem_write_data = load_data;
          end else begin
            mem_we = 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Table-driven bench for mem_stage with a queue of expected results.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_write_reg;
  logic        ex_we;
  logic [31:0] ex_write_data;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [4:0]  mem_write_reg;
  logic        mem_we;
  logic [31:0] mem_write_data;
  logic        stall_req, exc_misalign, exc_bus;

  int total = 0;
  int bad   = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_write_reg(ex_write_reg), .ex_we(ex_we), .ex_write_data(ex_write_data),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_write_reg(mem_write_reg), .mem_we(mem_we), .mem_write_data(mem_write_data),
    .stall_req(stall_req), .exc_misalign(exc_misalign), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  wreg;
    logic        we;
    logic [31:0] alu;
    int          ack_dly;
    logic [31:0] rdata;
    int          exp_stalls;
    logic        exp_dwe;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mwe;
    logic [31:0] exp_mdata;
    logic        exp_mis;
    logic        exp_bus;
  } vec_t;

  typedef struct {
    int          stalls;
    logic [4:0]  mreg;
    logic        mwe;
    logic [31:0] mdata;
    logic        mis;
    logic        bus;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=0x%08h req=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [4:0] wreg,
                              input logic we, input logic [31:0] alu, input int ack_dly,
                              input logic [31:0] rdata, input int stalls, input logic dwe,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic mwe, input logic [31:0] mdata,
                              input logic mis, input logic bus);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.wreg = wreg; v.we = we; v.alu = alu;
    v.ack_dly = ack_dly; v.rdata = rdata; v.exp_stalls = stalls; v.exp_dwe = dwe;
    v.exp_be = be; v.exp_wdata = wdata; v.exp_mwe = mwe; v.exp_mdata = mdata;
    v.exp_mis = mis; v.exp_bus = bus;
    return v;
  endfunction

  // Drives one instruction, services the bus with the requested ack delay,
  // and checks the cycle in which the stage releases the pipeline.
  task automatic apply(input vec_t v);
    exp_t e;
    int   stalls;
    ex_mem_op = v.op; ex_mem_addr = v.addr; ex_store_data = v.sdata;
    ex_write_reg = v.wreg; ex_we = v.we; ex_write_data = v.alu;
    dmem_rdata = v.rdata; dmem_ack = 1'b0;
    e.stalls = v.exp_stalls; e.mreg = v.wreg; e.mwe = v.exp_mwe;
    e.mdata = v.exp_mdata; e.mis = v.exp_mis; e.bus = v.exp_bus;
    sbq.push_back(e);
    #1;
    stalls = 0;
    while (stall_req === 1'b1 && stalls < 20) begin
      chk("req_held", {31'd0, dmem_req}, 32'd1);
      chk("mem_we_bubble", {31'd0, mem_we}, 32'd0);
      if (stalls == 0) begin
        chk("bus_we", {31'd0, dmem_we}, {31'd0, v.exp_dwe});
        chk("bus_addr", dmem_addr, {v.addr[31:2], 2'b00});
        chk("bus_be", {28'd0, dmem_be}, {28'd0, v.exp_be});
        if (v.exp_dwe) chk("bus_wdata", dmem_wdata, v.exp_wdata);
      end
      dmem_ack = (stalls == v.ack_dly);
      stalls++;
      tick();
      #1;
    end
    e = sbq.pop_front();
    chk("stall_cycles", stalls, e.stalls);
    chk("final_req", {31'd0, dmem_req}, 32'd0);
    chk("mem_write_reg", {27'd0, mem_write_reg}, {27'd0, e.mreg});
    chk("mem_we", {31'd0, mem_we}, {31'd0, e.mwe});
    if (e.mwe) chk("mem_write_data", mem_write_data, e.mdata);
    chk("exc_misalign", {31'd0, exc_misalign}, {31'd0, e.mis});
    chk("exc_bus", {31'd0, exc_bus}, {31'd0, e.bus});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_dwe"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, "_be"}, {28'd0, dmem_be}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
    chk({tag, "_mwe"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mreg"}, {27'd0, mem_write_reg}, 32'd0);
    chk({tag, "_mdata"}, mem_write_data, 32'd0);
    chk({tag, "_excm"}, {31'd0, exc_misalign}, 32'd0);
    chk({tag, "_excb"}, {31'd0, exc_bus}, 32'd0);
  endtask

  initial begin
    //         op       addr          sdata         reg we alu          dly rdata         st dwe be       wdata         mwe mdata         mis bus
    vecs.push_back(mk(MEM_NONE, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 99, 32'h0, 0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h1234, 1'b0, 1'b0));
    vecs.push_back(mk(MEM_LB, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0, 2, 32'h80FF_0011, 3, 1'b0, 4'b1000, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0));
    vecs.push_back(mk(MEM_SH, 32'h202, 32'h0000_ABCD, 5'd0, 1'b0, 32'h0, 0, 32'h0, 1, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(MEM_LW, 32'h101, 32'h0, 5'd3, 1'b1, 32'h0, 0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(MEM_LBU, 32'h102, 32'h0, 5'd8, 1'b1, 32'h0, 1, 32'h12AB_3456, 2, 1'b0, 4'b0100, 32'h0, 1'b1, 32'h0000_00AB, 1'b0, 1'b0));
    vecs.push_back(mk(MEM_LH, 32'h102, 32'h0, 5'd9, 1'b1, 32'h0, 0, 32'h8765_4321, 1, 1'b0, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8765, 1'b0, 1'b0));
    vecs.push_back(mk(MEM_LHU, 32'h100, 32'h0, 5'd10, 1'b1, 32'h0, 0, 32'h8765_F321, 1, 1'b0, 4'b0011, 32'h0, 1'b1, 32'h0000_F321, 1'b0, 1'b0));
    vecs.push_back(mk(MEM_LW, 32'h300, 32'h0, 5'd11, 1'b1, 32'h0, 4, 32'hDEAD_BEEF, 5, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0));
    vecs.push_back(mk(MEM_SB, 32'h301, 32'h0000_55AA, 5'd0, 1'b0, 32'h0, 0, 32'h0, 1, 1'b1, 4'b0010, 32'hAAAA_AAAA, 1'b0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(MEM_SW, 32'h400, 32'h0123_4567, 5'd0, 1'b0, 32'h0, 2, 32'h0, 3, 1'b1, 4'b1111, 32'h0123_4567, 1'b0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(MEM_LH, 32'h103, 32'h0, 5'd12, 1'b1, 32'h0, 0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(MEM_SH, 32'h201, 32'h1111, 5'd0, 1'b0, 32'h0, 0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(MEM_LB, 32'h100, 32'h0, 5'd13, 1'b1, 32'h0, 0, 32'h0000_007F, 1, 1'b0, 4'b0001, 32'h0, 1'b1, 32'h0000_007F, 1'b0, 1'b0));

    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    ex_mem_op = MEM_NONE; ex_mem_addr = 32'h0; ex_store_data = 32'h0;
    ex_write_reg = 5'd5; ex_we = 1'b1; ex_write_data = 32'h1234;
    tick(); tick();
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      apply(vecs[i]);
      tick();
    end

    // Timeout, then a late ack during DONE and during the next IDLE.
    apply(mk(MEM_LW, 32'h500, 32'h0, 5'd14, 1'b1, 32'h0, 99, 32'h0, 5, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1));
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    tick();
    ex_mem_op = MEM_NONE; ex_write_reg = 5'd15; ex_we = 1'b1; ex_write_data = 32'h0000_0042;
    dmem_ack = 1'b1;
    #1;
    chk("late_ack_stall", {31'd0, stall_req}, 32'd0);
    chk("late_ack_excb", {31'd0, exc_bus}, 32'd0);
    chk("late_ack_mwe", {31'd0, mem_we}, 32'd1);
    chk("late_ack_mdata", mem_write_data, 32'h0000_0042);
    tick();
    apply(mk(MEM_LW, 32'h600, 32'h0, 5'd16, 1'b1, 32'h0, 0, 32'hCAFE_F00D, 1, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0));
    tick();

    // Reset while BUSY.
    ex_mem_op = MEM_LW; ex_mem_addr = 32'h700; ex_write_reg = 5'd17; ex_we = 1'b1;
    dmem_ack = 1'b0;
    #1;
    chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
    tick(); tick();
    #1;
    chk("busy_stall", {31'd0, stall_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_req", {31'd0, dmem_req}, 32'd0);
    tick();
    #1;
    chk_reset_outputs("rst_busy");
    rst = 1'b0;
    ex_mem_op = MEM_NONE; ex_write_reg = 5'd9; ex_we = 1'b1; ex_write_data = 32'h77;
    #1;
    chk("post_rst_stall", {31'd0, stall_req}, 32'd0);
    chk("post_rst_mreg", {27'd0, mem_write_reg}, 32'd9);
    chk("post_rst_mdata", mem_write_data, 32'h77);
    tick();
    apply(mk(MEM_LHU, 32'h702, 32'h0, 5'd18, 1'b1, 32'h0, 0, 32'hBEEF_0000, 1, 1'b0, 4'b1100, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
